// File: rtl/data_cache_sa.sv
// Purpose : set-associative (1 or 2 way), write-back, write-allocate data cache.
// Latency : hits complete in the same cycle; a miss stalls 2 cycles clean / 3 dirty plus memory wait.
// Backpr. : stall holds the CPU request; mem_we/mem_re are held with stable addr/data until mem_ready.
// Ports   : clk/rst (sync, active-high); CPU side address/writeData/memWrite/memRead -> readData/stall;
//           memory side mem_addr/mem_wdata/mem_we/mem_re <- mem_rdata/mem_ready; hit_count/miss_count.
module data_cache_sa #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memWrite,
  input  logic              memRead,
  output logic [DATA_W-1:0] readData,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;

  // Storage is always sized for two ways; with WAYS=1 way 1 is never filled.
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;      // way to evict next in each set
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [DATA_W-1:0] data_q  [2][SETS];
  logic [31:0]       hit_q, miss_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req, hit0, hit1, hit, hit_way, victim_sel;
  logic             hit_evt, miss_evt, fill_evt;
  logic             unused_addr_bits;

  assign idx              = address[2 +: IDX_W];
  assign tag              = address[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^address[1:0];
  assign req              = memRead | memWrite;
  assign hit0             = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1             = (WAYS == 2) && valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit              = hit0 | hit1;
  assign hit_way          = hit1;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

  // Prefer an empty way (way 0 first); only evict by LRU when the set is full.
  always_comb begin
    victim_sel = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[0][idx])      victim_sel = 1'b0;
      else if (!valid_q[1][idx]) victim_sel = 1'b1;
      else                       victim_sel = lru_q[idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    readData  = '0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    fill_evt  = 1'b0;
    // While reset is asserted every output is forced quiet and no state update is requested.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              hit_evt = 1'b1;
              if (!memWrite) readData = data_q[hit_way][idx];
            end else begin
              miss_evt = 1'b1;
              stall    = 1'b1;
              victim_d = victim_sel;
              state_d  = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          stall     = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_q[victim_q][idx], idx, 2'b00};
          mem_wdata = data_q[victim_q][idx];
          if (mem_ready) state_d = FILL;
        end
        FILL: begin
          stall    = 1'b1;
          mem_re   = 1'b1;
          mem_addr = {tag, idx, 2'b00};
          if (mem_ready) begin
            fill_evt = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      victim_q   <= 1'b0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit_evt) begin
        lru_q[idx] <= ~hit_way;
        if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
        if (memWrite) dirty_q[hit_way][idx] <= 1'b1;
      end
      if (miss_evt && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
      if (fill_evt) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (hit_evt && memWrite) data_q[hit_way][idx] <= writeData;
    if (fill_evt) begin
      tag_q[victim_q][idx]  <= tag;
      data_q[victim_q][idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_cache_sa.sv
// Purpose : scoreboard bench for data_cache_sa; instance 0 is 2-way, instance 1 is direct-mapped.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpr. : a small memory responder grants every memory request in the cycle it appears.
module tb_data_cache_sa;
  localparam int K_READ = 0;
  localparam int K_WB   = 1;
  localparam int K_FILL = 2;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic [31:0] address   [2];
  logic [31:0] writeData [2];
  logic        memWrite  [2];
  logic        memRead   [2];
  logic [31:0] readData  [2];
  logic        stall     [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_we    [2];
  logic        mem_re    [2];
  logic [31:0] mem_rdata [2];
  logic        mem_ready [2];
  logic [31:0] hit_count [2];
  logic [31:0] miss_count[2];

  exp_t        exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc;

  always #5 clk = ~clk;

  data_cache_sa #(.ADDR_W(32), .DATA_W(32), .SETS(64), .WAYS(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .address(address[0]), .writeData(writeData[0]),
    .memWrite(memWrite[0]), .memRead(memRead[0]), .readData(readData[0]), .stall(stall[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .hit_count(hit_count[0]), .miss_count(miss_count[0]));

  data_cache_sa #(.ADDR_W(32), .DATA_W(32), .SETS(64), .WAYS(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .address(address[1]), .writeData(writeData[1]),
    .memWrite(memWrite[1]), .memRead(memRead[1]), .readData(readData[1]), .stall(stall[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .hit_count(hit_count[1]), .miss_count(miss_count[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int kind, input logic [31:0] a, input logic [31:0] dat);
    exp_t e;
    e.dut  = d;
    e.kind = kind;
    e.addr = a;
    e.data = dat;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int d, input int kind, input logic [31:0] a, input logic [31:0] dat);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: dut%0d kind %0d addr 0x%08h data 0x%08h, expected nothing", d, kind, a, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != kind || e.addr !== a || (kind != K_FILL && e.data !== dat)) begin
        n_fail++;
        $display("FAIL event: got dut%0d kind %0d addr 0x%08h data 0x%08h, expected dut%0d kind %0d addr 0x%08h data 0x%08h",
                 d, kind, a, dat, e.dut, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every memory handshake and every completed load is matched against the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        if (mem_we[d] && mem_ready[d]) observe(d, K_WB, mem_addr[d], mem_wdata[d]);
        if (mem_re[d] && mem_ready[d]) observe(d, K_FILL, mem_addr[d], 32'h0);
        if (memRead[d] && !memWrite[d] && !stall[d]) observe(d, K_READ, address[d], readData[d]);
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hBAD0_0000 ^ a;
  endfunction

  // Issue one CPU access (called at posedge+1); returns the number of stalled cycles.
  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output int stalls);
    stalls       = 0;
    address[d]   = a;
    writeData[d] = wd;
    memWrite[d]  = wr;
    memRead[d]   = !wr;
    forever begin
      #1;
      if (!stall[d]) begin
        @(posedge clk); #1;
        break;
      end
      if (mem_we[d]) begin
        mem_ready[d] = 1'b1;
        mem_model[mem_addr[d]] = mem_wdata[d];
      end else if (mem_re[d]) begin
        mem_ready[d] = 1'b1;
        mem_rdata[d] = model_rd(mem_addr[d]);
      end
      @(posedge clk); #1;
      mem_ready[d] = 1'b0;
      mem_rdata[d] = 32'h0;
      stalls++;
      if (stalls > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL access_timeout: dut%0d addr 0x%08h still stalled after %0d cycles, expected completion", d, a, stalls);
        break;
      end
    end
    memWrite[d] = 1'b0;
    memRead[d]  = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; address[d] = 0; writeData[d] = 0; memWrite[d] = 0; memRead[d] = 0;
      mem_rdata[d] = 0; mem_ready[d] = 0;
    end
    mem_model[32'h0]   = 32'hDEAD_BEEF;
    mem_model[32'h200] = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", 32'(stall[d]), 32'h0);
      chk("rst_mem_we", 32'(mem_we[d]), 32'h0);
      chk("rst_mem_re", 32'(mem_re[d]), 32'h0);
      chk("rst_mem_addr", mem_addr[d], 32'h0);
      chk("rst_mem_wdata", mem_wdata[d], 32'h0);
      chk("rst_readData", readData[d], 32'h0);
      chk("rst_hit_count", hit_count[d], 32'h0);
      chk("rst_miss_count", miss_count[d], 32'h0);
    end

    // 1: cold read miss, clean fill from 0x0
    push(0, K_FILL, 32'h0, 32'h0);
    push(0, K_READ, 32'h0, 32'hDEAD_BEEF);
    access(0, 1'b0, 32'h0, 32'h0, cyc);
    chk("t1_stall_cycles", 32'(cyc), 32'd2);
    chk("t1_miss_count", miss_count[0], 32'd1);
    chk("t1_hit_count", hit_count[0], 32'd1);

    // 2: write hit then read back, no memory traffic
    access(0, 1'b1, 32'h0, 32'hF0F0_F0F0, cyc);
    chk("t2_write_stall", 32'(cyc), 32'd0);
    push(0, K_READ, 32'h0, 32'hF0F0_F0F0);
    access(0, 1'b0, 32'h0, 32'h0, cyc);
    chk("t2_read_stall", 32'(cyc), 32'd0);
    chk("t2_hit_count", hit_count[0], 32'd3);

    // 3: 0x100 shares set 0; fills the empty way, then both tags hit
    push(0, K_FILL, 32'h100, 32'h0);
    access(0, 1'b1, 32'h100, 32'h1, cyc);
    chk("t3_write_miss_stall", 32'(cyc), 32'd2);
    push(0, K_READ, 32'h0, 32'hF0F0_F0F0);
    access(0, 1'b0, 32'h0, 32'h0, cyc);
    push(0, K_READ, 32'h100, 32'h1);
    access(0, 1'b0, 32'h100, 32'h0, cyc);
    chk("t3_hit_count", hit_count[0], 32'd6);
    chk("t3_miss_count", miss_count[0], 32'd2);

    // 4: third tag evicts LRU way (0x0, dirty): write-back then fill
    push(0, K_WB, 32'h0, 32'hF0F0_F0F0);
    push(0, K_FILL, 32'h200, 32'h0);
    push(0, K_READ, 32'h200, 32'h2222_2222);
    access(0, 1'b0, 32'h200, 32'h0, cyc);
    chk("t4_dirty_stall_cycles", 32'(cyc), 32'd3);
    chk("t4_miss_count", miss_count[0], 32'd3);
    chk("t4_hit_count", hit_count[0], 32'd7);

    // 5: read 0x0 evicts dirty 0x100; fill held off, then reset mid-fill
    push(0, K_WB, 32'h100, 32'h1);
    address[0] = 32'h0;
    memRead[0] = 1'b1;
    #1;
    chk("t5_idle_miss_stall", 32'(stall[0]), 32'h1);
    @(posedge clk); #1;
    mem_ready[0] = 1'b1;
    #1;
    chk("t5_wb_mem_we", 32'(mem_we[0]), 32'h1);
    @(posedge clk); #1;
    mem_ready[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("t5_fill_stall", 32'(stall[0]), 32'h1);
      chk("t5_fill_mem_re", 32'(mem_re[0]), 32'h1);
      chk("t5_fill_mem_addr", mem_addr[0], 32'h0);
      if (c == 3) begin
        rst[0] = 1'b1;
        #1;
        chk("t5_rst_stall", 32'(stall[0]), 32'h0);
        chk("t5_rst_mem_re", 32'(mem_re[0]), 32'h0);
      end
      @(posedge clk); #1;
    end
    rst[0]     = 1'b0;
    memRead[0] = 1'b0;
    #1;
    chk("t5_post_rst_stall", 32'(stall[0]), 32'h0);
    chk("t5_post_rst_mem_re", 32'(mem_re[0]), 32'h0);
    chk("t5_post_rst_miss", miss_count[0], 32'h0);
    push(0, K_FILL, 32'h0, 32'h0);
    push(0, K_READ, 32'h0, 32'hF0F0_F0F0);
    access(0, 1'b0, 32'h0, 32'h0, cyc);
    chk("t5_reread_stall", 32'(cyc), 32'd2);
    chk("t5_reread_miss", miss_count[0], 32'd1);
    chk("t5_reread_hit", hit_count[0], 32'd1);

    // 6: direct-mapped instance: conflicting tags force write-back
    mem_model[32'h100] = 32'h0000_0B0B;
    push(1, K_FILL, 32'h0, 32'h0);
    access(1, 1'b1, 32'h0, 32'h1234_5678, cyc);
    chk("t6_write_stall", 32'(cyc), 32'd2);
    push(1, K_WB, 32'h0, 32'h1234_5678);
    push(1, K_FILL, 32'h100, 32'h0);
    push(1, K_READ, 32'h100, 32'h0000_0B0B);
    access(1, 1'b0, 32'h100, 32'h0, cyc);
    chk("t6_read_stall", 32'(cyc), 32'd3);
    chk("t6_miss_count", miss_count[1], 32'd2);
    chk("t6_hit_count", hit_count[1], 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
